// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between the IF fetch port and the MEM data port,
// one transaction at a time, with per-port result holding and a watchdog abort.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 30
) (
  input  logic              clock,
  input  logic              reset,
  // instruction-fetch port
  input  logic              IF_Read,
  input  logic [ADDR_W-1:0] IF_Address,
  input  logic              IF_Accept,
  output logic [31:0]       IF_Data,
  output logic              Inst_Stall,
  output logic              IF_BusError,
  // data-memory port
  input  logic              D_Read,
  input  logic              D_Write,
  input  logic [ADDR_W-1:0] D_Address,
  input  logic [31:0]       D_WriteData,
  input  logic [3:0]        D_ByteEnable,
  input  logic              M_Accept,
  output logic [31:0]       D_ReadData,
  output logic              M_Stall_Controller,
  output logic              D_BusError,
  // external bus
  output logic              Bus_Req,
  output logic              Bus_We,
  output logic [ADDR_W-1:0] Bus_Address,
  output logic [31:0]       Bus_WriteData,
  output logic [3:0]        Bus_ByteEnable,
  input  logic [31:0]       Bus_ReadData,
  input  logic              Bus_Ack
);

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       i_done;
  logic       d_done;
  logic [7:0] wd_count;

  logic       i_pend;
  logic       d_pend;
  logic       start_inst;
  logic       start_data;
  logic       finish_ok;
  logic       finish_abort;
  logic       inst_end;
  logic       data_end;

  assign i_pend = IF_Read & ~i_done;
  assign d_pend = (D_Read | D_Write) & ~d_done;

  assign Inst_Stall         = i_pend;
  assign M_Stall_Controller = d_pend;

  assign inst_end = (finish_ok | finish_abort) & (state == INST);
  assign data_end = (finish_ok | finish_abort) & (state == DATA);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    start_inst   = 1'b0;
    start_data   = 1'b0;
    finish_ok    = 1'b0;
    finish_abort = 1'b0;
    unique case (state)
      IDLE: begin
        // Data wins: the MEM stage holds the older instruction.
        if (d_pend) begin
          state_next = DATA;
          start_data = 1'b1;
        end else if (i_pend) begin
          state_next = INST;
          start_inst = 1'b1;
        end
      end
      INST, DATA: begin
        if (Bus_Ack) begin
          finish_ok  = 1'b1;
          state_next = IDLE;
        end else if (wd_count == WD_LIMIT) begin
          finish_abort = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Bus_Req        <= 1'b0;
      Bus_We         <= 1'b0;
      Bus_Address    <= '0;
      Bus_WriteData  <= '0;
      Bus_ByteEnable <= '0;
      wd_count       <= '0;
    end else if (start_data) begin
      // Read and write together is treated as a write.
      Bus_Req        <= 1'b1;
      Bus_We         <= D_Write;
      Bus_Address    <= D_Address;
      Bus_WriteData  <= D_Write ? D_WriteData : 32'h0;
      Bus_ByteEnable <= D_Write ? D_ByteEnable : 4'hF;
      wd_count       <= '0;
    end else if (start_inst) begin
      Bus_Req        <= 1'b1;
      Bus_We         <= 1'b0;
      Bus_Address    <= IF_Address;
      Bus_WriteData  <= 32'h0;
      Bus_ByteEnable <= 4'hF;
      wd_count       <= '0;
    end else if (finish_ok || finish_abort) begin
      Bus_Req <= 1'b0;
    end else if (state != IDLE) begin
      wd_count <= wd_count + 8'd1;
    end
  end

  // Results stay put until the owning pipeline register consumes them;
  // a completion on the same edge as Accept keeps the result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      IF_Data     <= '0;
      D_ReadData  <= '0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      IF_BusError <= 1'b0;
      D_BusError  <= 1'b0;
    end else begin
      if (finish_ok && state == INST) begin
        IF_Data <= Bus_ReadData;
      end
      if (finish_ok && state == DATA && !Bus_We) begin
        D_ReadData <= Bus_ReadData;
      end

      if (inst_end) begin
        i_done      <= 1'b1;
        IF_BusError <= finish_abort;
      end else if (IF_Accept) begin
        i_done      <= 1'b0;
        IF_BusError <= 1'b0;
      end

      if (data_end) begin
        d_done     <= 1'b1;
        D_BusError <= finish_abort;
      end else if (M_Accept) begin
        d_done     <= 1'b0;
        D_BusError <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed and random transaction records checked
// cycle by cycle, plus hand-written hold, drop and reset sequences.
module tb_mem_bus_arbiter;

  localparam int TO = 4;
  localparam int AW = 30;
  localparam int NDIR = 6;
  localparam int NV = 66;

  logic          clock;
  logic          reset;
  logic          IF_Read;
  logic [AW-1:0] IF_Address;
  logic          IF_Accept;
  logic [31:0]   IF_Data;
  logic          Inst_Stall;
  logic          IF_BusError;
  logic          D_Read;
  logic          D_Write;
  logic [AW-1:0] D_Address;
  logic [31:0]   D_WriteData;
  logic [3:0]    D_ByteEnable;
  logic          M_Accept;
  logic [31:0]   D_ReadData;
  logic          M_Stall_Controller;
  logic          D_BusError;
  logic          Bus_Req;
  logic          Bus_We;
  logic [AW-1:0] Bus_Address;
  logic [31:0]   Bus_WriteData;
  logic [3:0]    Bus_ByteEnable;
  logic [31:0]   Bus_ReadData;
  logic          Bus_Ack;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.TIMEOUT(TO), .ADDR_W(AW)) dut (
    .clock              (clock),
    .reset              (reset),
    .IF_Read            (IF_Read),
    .IF_Address         (IF_Address),
    .IF_Accept          (IF_Accept),
    .IF_Data            (IF_Data),
    .Inst_Stall         (Inst_Stall),
    .IF_BusError        (IF_BusError),
    .D_Read             (D_Read),
    .D_Write            (D_Write),
    .D_Address          (D_Address),
    .D_WriteData        (D_WriteData),
    .D_ByteEnable       (D_ByteEnable),
    .M_Accept           (M_Accept),
    .D_ReadData         (D_ReadData),
    .M_Stall_Controller (M_Stall_Controller),
    .D_BusError         (D_BusError),
    .Bus_Req            (Bus_Req),
    .Bus_We             (Bus_We),
    .Bus_Address        (Bus_Address),
    .Bus_WriteData      (Bus_WriteData),
    .Bus_ByteEnable     (Bus_ByteEnable),
    .Bus_ReadData       (Bus_ReadData),
    .Bus_Ack            (Bus_Ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "time limit");
  end

  // One transaction scenario: requests raised in cycle 0; ack cycles are absolute.
  // Windows give the expected Bus_Req cycles; each stall drops the cycle after its window.
  typedef struct {
    string         name;
    bit            ir, dr, dw;
    logic [AW-1:0] ia, da;
    logic [31:0]   wd;
    logic [3:0]    be;
    logic [31:0]   ird, drd;
    int            ack_i_at, ack_d_at;
    int            i_first, i_last, d_first, d_last;
    logic [31:0]   exp_if, exp_d;
    bit            exp_ie, exp_de;
  } vec_t;

  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t dv(string n, bit ir, bit dr, bit dw, logic [AW-1:0] ia,
                              logic [AW-1:0] da, logic [31:0] wd, logic [3:0] be,
                              logic [31:0] ird, logic [31:0] drd, int ack_i, int ack_d,
                              int i_f, int i_l, int d_f, int d_l, logic [31:0] eif,
                              logic [31:0] ed, bit eie, bit ede);
    vec_t v;
    v.name = n; v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.wd = wd;
    v.be = be; v.ird = ird; v.drd = drd; v.ack_i_at = ack_i; v.ack_d_at = ack_d;
    v.i_first = i_f; v.i_last = i_l; v.d_first = d_f; v.d_last = d_l;
    v.exp_if = eif; v.exp_d = ed; v.exp_ie = eie; v.exp_de = ede;
    return v;
  endfunction

  // Reference model: data is served first, each access lasts delay+1 cycles or
  // TIMEOUT cycles when never acked, and one idle cycle separates accesses.
  function automatic vec_t make_rand(int idx, logic [31:0] prev_if, logic [31:0] prev_d);
    vec_t v;
    int   sel, kind, k_i, k_d, pos;
    bit   has_d, acked;
    sel   = $urandom_range(1, 3);
    kind  = $urandom_range(0, 3);
    has_d = sel[1];
    v.name = $sformatf("rnd%0d", idx);
    v.ir  = sel[0];
    v.dr  = has_d && (kind != 1);
    v.dw  = has_d && (kind == 1 || kind == 2);
    v.ia  = AW'($urandom);
    v.da  = AW'($urandom);
    v.wd  = $urandom;
    v.be  = 4'($urandom);
    v.ird = $urandom;
    v.drd = $urandom;
    k_i   = $urandom_range(0, TO);
    k_d   = $urandom_range(0, TO);
    pos   = 1;
    v.ack_i_at = -1; v.ack_d_at = -1;
    v.i_first = 0; v.i_last = 0; v.d_first = 0; v.d_last = 0;
    v.exp_if = prev_if; v.exp_d = prev_d; v.exp_ie = 1'b0; v.exp_de = 1'b0;
    if (has_d) begin
      acked     = k_d < TO;
      v.d_first = 1;
      v.d_last  = 1 + (acked ? k_d : TO - 1);
      if (acked) v.ack_d_at = 1 + k_d;
      v.exp_de  = !acked;
      if (acked && !v.dw) v.exp_d = v.drd;
      pos = v.d_last + 2;
    end
    if (v.ir) begin
      acked     = k_i < TO;
      v.i_first = pos;
      v.i_last  = pos + (acked ? k_i : TO - 1);
      if (acked) begin
        v.ack_i_at = pos + k_i;
        v.exp_if   = v.ird;
      end
      v.exp_ie = !acked;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int last;
    bit has_d, in_i, in_d;
    has_d = v.dr || v.dw;
    last  = (v.i_last > v.d_last) ? v.i_last : v.d_last;
    IF_Read = v.ir; IF_Address = v.ia;
    D_Read = v.dr; D_Write = v.dw; D_Address = v.da;
    D_WriteData = v.wd; D_ByteEnable = v.be;
    for (int c = 0; c <= last + 1; c++) begin
      Bus_Ack      = (c == v.ack_i_at) || (c == v.ack_d_at);
      Bus_ReadData = (c == v.ack_d_at) ? v.drd : (c == v.ack_i_at) ? v.ird : 32'hA5A5_5A5A;
      @(negedge clock);
      in_i = v.ir && c >= v.i_first && c <= v.i_last;
      in_d = has_d && c >= v.d_first && c <= v.d_last;
      check({v.name, ".m_stall"}, M_Stall_Controller, has_d && c <= v.d_last);
      check({v.name, ".inst_stall"}, Inst_Stall, v.ir && c <= v.i_last);
      check({v.name, ".bus_req"}, Bus_Req, in_i || in_d);
      if (in_d) begin
        check({v.name, ".d_addr"}, Bus_Address, v.da);
        check({v.name, ".d_we"}, Bus_We, v.dw);
        check({v.name, ".d_be"}, Bus_ByteEnable, v.dw ? v.be : 4'hF);
        if (v.dw) check({v.name, ".d_wdata"}, Bus_WriteData, v.wd);
      end
      if (in_i) begin
        check({v.name, ".i_addr"}, Bus_Address, v.ia);
        check({v.name, ".i_we"}, Bus_We, 1'b0);
        check({v.name, ".i_be"}, Bus_ByteEnable, 4'hF);
      end
      tick();
    end
    Bus_Ack = 1'b0;
    check({v.name, ".if_data"}, IF_Data, v.exp_if);
    check({v.name, ".d_rdata"}, D_ReadData, v.exp_d);
    check({v.name, ".if_err"}, IF_BusError, v.exp_ie);
    check({v.name, ".d_err"}, D_BusError, v.exp_de);
    IF_Read = 1'b0; D_Read = 1'b0; D_Write = 1'b0;
    IF_Accept = 1'b1; M_Accept = 1'b1;
    tick();
    IF_Accept = 1'b0; M_Accept = 1'b0;
    @(negedge clock);
    check({v.name, ".if_err_clr"}, IF_BusError, 1'b0);
    check({v.name, ".d_err_clr"}, D_BusError, 1'b0);
    check({v.name, ".idle_req"}, Bus_Req, 1'b0);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    IF_Read = 1'b0; IF_Address = '0; IF_Accept = 1'b0;
    D_Read = 1'b0; D_Write = 1'b0; D_Address = '0; D_WriteData = '0;
    D_ByteEnable = '0; M_Accept = 1'b0; Bus_ReadData = '0; Bus_Ack = 1'b0;

    vecs[0] = dv("fetch", 1, 0, 0, 30'h100, 30'h0, 32'h0, 4'h0, 32'h2402000A, 32'h0,
                 3, -1, 1, 3, 0, 0, 32'h2402000A, 32'h0, 0, 0);
    vecs[1] = dv("contend", 1, 1, 0, 30'h40, 30'h80, 32'h0, 4'h0, 32'h33334444, 32'h11112222,
                 4, 1, 3, 4, 1, 1, 32'h33334444, 32'h11112222, 0, 0);
    vecs[2] = dv("store", 0, 0, 1, 30'h0, 30'h20, 32'hDEADBEEF, 4'b0011, 32'h0, 32'hBAD0BAD0,
                 -1, 1, 0, 0, 1, 1, 32'h33334444, 32'h11112222, 0, 0);
    vecs[3] = dv("d_timeout", 0, 1, 0, 30'h0, 30'h55, 32'h0, 4'h0, 32'h0, 32'h0,
                 -1, -1, 0, 0, 1, 4, 32'h33334444, 32'h11112222, 0, 1);
    vecs[4] = dv("i_timeout", 1, 1, 0, 30'h104, 30'h60, 32'h0, 4'h0, 32'h77777777, 32'hCAFEF00D,
                 -1, 2, 4, 7, 1, 2, 32'h33334444, 32'hCAFEF00D, 1, 0);
    vecs[5] = dv("rw_both", 0, 1, 1, 30'h0, 30'h30, 32'h01234567, 4'hC, 32'h0, 32'h99999999,
                 -1, 1, 0, 0, 1, 1, 32'h33334444, 32'hCAFEF00D, 0, 0);
    for (int n = NDIR; n < NV; n++) begin
      vecs[n] = make_rand(n, vecs[n-1].exp_if, vecs[n-1].exp_d);
    end

    #12;
    check("rst.bus_req", Bus_Req, 1'b0);
    check("rst.bus_we", Bus_We, 1'b0);
    check("rst.bus_addr", Bus_Address, '0);
    check("rst.bus_wdata", Bus_WriteData, '0);
    check("rst.bus_be", Bus_ByteEnable, 4'h0);
    check("rst.if_data", IF_Data, '0);
    check("rst.d_rdata", D_ReadData, '0);
    check("rst.errs", {IF_BusError, D_BusError}, 2'b00);
    @(negedge clock);
    reset = 1'b0;
    tick();

    for (int n = 0; n < NV; n++) run_vec(vecs[n]);

    // Hold without re-fetch, stray acks in IDLE, then re-fetch after IF_Accept.
    IF_Read = 1'b1; IF_Address = 30'h200;
    @(negedge clock);
    check("hold.stall0", Inst_Stall, 1'b1);
    tick();
    Bus_Ack = 1'b1; Bus_ReadData = 32'h8C220004;
    @(negedge clock);
    check("hold.req1", Bus_Req, 1'b1);
    check("hold.addr1", Bus_Address, 30'h200);
    tick();
    for (int i = 0; i < 5; i++) begin
      Bus_Ack = (i == 2); Bus_ReadData = 32'hFFFF0000;
      @(negedge clock);
      check("hold.stall", Inst_Stall, 1'b0);
      check("hold.noreq", Bus_Req, 1'b0);
      check("hold.data", IF_Data, 32'h8C220004);
      tick();
    end
    Bus_Ack = 1'b0; IF_Accept = 1'b1; IF_Address = 30'h204;
    @(negedge clock);
    check("hold.acc_stall", Inst_Stall, 1'b0);
    tick();
    IF_Accept = 1'b0;
    @(negedge clock);
    check("refetch.idle_stall", Inst_Stall, 1'b1);
    check("refetch.idle_req", Bus_Req, 1'b0);
    tick();
    IF_Accept = 1'b1;
    @(negedge clock);
    check("refetch.req", Bus_Req, 1'b1);
    check("refetch.addr", Bus_Address, 30'h204);
    check("refetch.data_kept", IF_Data, 32'h8C220004);
    tick();
    IF_Accept = 1'b0; Bus_Ack = 1'b1; Bus_ReadData = 32'h00851020;
    @(negedge clock);
    check("refetch.busy_stall", Inst_Stall, 1'b1);
    tick();
    Bus_Ack = 1'b0;
    @(negedge clock);
    check("refetch.done", Inst_Stall, 1'b0);
    check("refetch.data", IF_Data, 32'h00851020);
    tick();
    IF_Read = 1'b0; IF_Accept = 1'b1;
    tick();
    IF_Accept = 1'b0;
    tick();

    // A fetch withdrawn mid-transaction still completes and its result is held.
    IF_Read = 1'b1; IF_Address = 30'h300;
    tick();
    @(negedge clock);
    check("drop.req", Bus_Req, 1'b1);
    tick();
    IF_Read = 1'b0; Bus_Ack = 1'b1; Bus_ReadData = 32'h12345678;
    @(negedge clock);
    check("drop.req_kept", Bus_Req, 1'b1);
    tick();
    Bus_Ack = 1'b0;
    @(negedge clock);
    check("drop.idle", Bus_Req, 1'b0);
    check("drop.data", IF_Data, 32'h12345678);
    tick();
    IF_Read = 1'b1;
    @(negedge clock);
    check("drop.held_stall", Inst_Stall, 1'b0);
    tick();
    IF_Read = 1'b0; IF_Accept = 1'b1;
    @(negedge clock);
    check("drop.no_refetch", Bus_Req, 1'b0);
    tick();
    IF_Accept = 1'b0;
    tick();

    // Asynchronous reset while a data read is on the bus; a late ack is ignored.
    D_Read = 1'b1; D_Address = 30'h77;
    tick();
    @(negedge clock);
    check("arst.req_before", Bus_Req, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("arst.req", Bus_Req, 1'b0);
    check("arst.addr", Bus_Address, '0);
    check("arst.be", Bus_ByteEnable, 4'h0);
    check("arst.if_data", IF_Data, '0);
    check("arst.d_rdata", D_ReadData, '0);
    D_Read = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    Bus_Ack = 1'b1; Bus_ReadData = 32'hDEAD0001;
    tick();
    Bus_Ack = 1'b0;
    @(negedge clock);
    check("arst.late_ack_data", D_ReadData, '0);
    check("arst.late_ack_req", Bus_Req, 1'b0);
    check("arst.late_ack_err", D_BusError, 1'b0);
    tick();
    D_Read = 1'b1; D_Address = 30'h10;
    tick();
    Bus_Ack = 1'b1; Bus_ReadData = 32'h600D600D;
    @(negedge clock);
    check("arst.new_req", Bus_Req, 1'b1);
    tick();
    Bus_Ack = 1'b0;
    @(negedge clock);
    check("arst.new_data", D_ReadData, 32'h600D600D);
    check("arst.new_stall", M_Stall_Controller, 1'b0);
    tick();
    D_Read = 1'b0; M_Accept = 1'b1;
    tick();
    M_Accept = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
